filter_line_ctrl_5x5: RTL
=========================

# filter_line_ctrl_5x5

Sequencing controller for the 5x5 line-buffer/window-align stage of the image filter pipeline. It counts columns and lines of the incoming Y/U/V raster and generates the align stage's memory read enable, line-memory rotation select, write/read addresses and vertical-padding flags. After the last input line it synthesises two flush lines so that the bottom two centre lines are emitted. It sits between the video timing input and the window-align stage and drives that stage's `i_mem_*` and `i_pad_y` inputs directly.

## Interface
Parameters:
- `MEM_ADDR_WIDTH`, 11: line-memory address width.
- `H_ACT`, 1920: active pixels per line. Constraint: 1 ≤ H_ACT ≤ 2^MEM_ADDR_WIDTH.
- `V_ACT`, 1080: active lines per frame. Constraint: V_ACT ≥ 5.
- `FLUSH_GAP`, 280: idle cycles before each flush line. Constraint: FLUSH_GAP ≥ 4.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  pipeline clock.
- `rstn`  in  1  async active-low reset.
- `i_vsync`  in  1  one-cycle frame-start pulse.
- `i_de`  in  1  input pixel valid, same cycle as `i_y/i_u/i_v` at the align stage.
- `o_mem_ren`  out  1  align-stage memory read enable.
- `o_mem_sel`  out  2  line-memory rotation select.
- `o_mem_waddr`  out  MEM_ADDR_WIDTH  write column address, aligned to the align stage's registered DE.
- `o_mem_raddr`  out  MEM_ADDR_WIDTH  read column address.
- `o_pad_y`  out  4  one-hot vertical pad flags, or all zero.
- `o_busy`  out  1  high from the first input line until the flush completes.
- `o_frame_done`  out  1  one-cycle pulse after the last flush line.
- `o_err`  out  1  sticky line-length error; cleared by `i_vsync`.

## Operation
- FSM states: IDLE, FILL, RUN, GAP, FLUSH, DONE.
- IDLE: waits for the first `i_de` after `i_vsync`, then enters FILL.
- FILL: covers input lines 0 and 1. Writes only; `o_mem_ren` stays 0.
- RUN: covers input lines 2 to V_ACT-1.
  - `o_mem_ren = i_de` (combinational from `i_de`).
  - Centre line c = input line - 2.
- GAP: counts FLUSH_GAP cycles, then enters FLUSH.
- FLUSH: controller-generated read burst of exactly H_ACT cycles; `i_de` is ignored.
  - Two flush lines are run, GAP→FLUSH→GAP→FLUSH, with c = V_ACT-2 and then c = V_ACT-1.
- DONE: pulses `o_frame_done` for one cycle, then returns to IDLE.
- Column counter `col`:
  - 0 at line start; increments on each active cycle (`i_de` or flush read).
  - `o_mem_raddr = col`.
  - `o_mem_waddr = col` registered by one cycle.
- Line end is the falling edge of `i_de`. At line end:
  - `col` clears to 0.
  - If the line length was not H_ACT, `o_err` sets. The line still counts as one line.
- `o_mem_sel` increments mod 4 after every line, FILL, RUN and FLUSH alike.
- `o_pad_y` is a function of c:
  - c = 0 → 4'b0001
  - c = 1 → 4'b0010
  - c = V_ACT-1 → 4'b0100
  - c = V_ACT-2 → 4'b1000
  - otherwise 0
  - FILL → 0
- `i_vsync` in any state, including mid-line or mid-flush:
  - next cycle: state = IDLE; `col`, line count, `o_mem_sel`, `o_pad_y` and `o_err` all cleared; `o_mem_ren` = 0.
  - An `i_de` in the same cycle as `i_vsync` is ignored.
- Extra `i_de` lines after V_ACT (seen in GAP/FLUSH) are ignored; no writes are counted.

## Timing
- All outputs reset to 0.
- `o_mem_ren` follows `i_de` with zero latency in RUN.
- In FLUSH, `o_mem_ren` is registered and high for exactly H_ACT consecutive cycles.
- `o_mem_waddr` lags `o_mem_raddr` by 1 cycle.
- Let act = `i_de` | flush read, with act_d1 and act_d2 its 1- and 2-cycle registered copies.
  - `o_mem_sel` and `o_pad_y` update on the edge where act_d2 = 1 and act_d1 = 0.
  - The new value is valid from the 3rd cycle after the last active cycle.
  - Both outputs are therefore stable for the whole read/window shift of each line.
- `o_pad_y` for the next line is valid before that line's first `o_mem_ren`.
- Required horizontal blanking is ≥ 4 cycles; this is the caller's responsibility and is not checked.
- `o_busy` rises with the first `i_de` of the frame and falls together with the `o_frame_done` pulse.

## Structure
- Package `filter_ctrl_pkg`:
  - FSM state enum.
  - Pad code constants PAD_TOP0 = 4'b0001, PAD_TOP1 = 4'b0010, PAD_BOT0 = 4'b0100, PAD_BOT1 = 4'b1000.
- Sub-module `filter_col_cnt`:
  - column counter with clear, enable and terminal-count flag.
  - Instantiated twice: as the column counter and as the GAP/flush-length timer.

## Test plan
- H_ACT=8, V_ACT=6, FLUSH_GAP=4, blanking 6:
  - lines 0–1 → `o_mem_ren` = 0.
  - lines 2–5 → `o_mem_ren` high 8 cycles per line; `o_mem_raddr` 0..7; `o_mem_waddr` 0..7 one cycle later.
- Same frame, per centre line → `o_pad_y` sequence 0001, 0010, 0000, 0000, 1000, 0100.
  - Two flush bursts of 8 cycles, each preceded by 4 idle cycles.
  - `o_frame_done` pulses once.
- Same frame, `o_mem_sel` per line → 0,1,2,3,0,1,2,3 (6 input lines + 2 flush).
  - Each change occurs exactly 3 cycles after the last active cycle.
- Line 3 driven with 7 pixels → `o_err` = 1 and stays set.
  - Next line's `o_mem_raddr` starts at 0.
  - `i_vsync` clears `o_err`.
- `i_vsync` during the first flush burst → next cycle `o_mem_ren` = 0, `o_mem_sel` = 0, `o_busy` = 0; no `o_frame_done`.
  - A following frame runs normally.
- `rstn` asserted mid-RUN → all outputs 0 immediately.
  - After release, `i_de` with no preceding `i_vsync` gives FILL behaviour: `o_mem_ren` stays 0 for 2 lines.

Source files
------------

// File: rtl/filter_ctrl_pkg.sv
// Shared types and constants for the 5x5 line-buffer sequencing controller.
package filter_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    RUN,
    GAP,
    FLUSH,
    DONE
  } state_t;

  localparam logic [3:0] PAD_TOP0 = 4'b0001;
  localparam logic [3:0] PAD_TOP1 = 4'b0010;
  localparam logic [3:0] PAD_BOT0 = 4'b0100;
  localparam logic [3:0] PAD_BOT1 = 4'b1000;

endpackage

// File: rtl/filter_col_cnt.sv
// Up-counter with synchronous clear (priority over enable) and a terminal-count compare.
module filter_col_cnt #(
  parameter int unsigned W = 12
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt,
  output logic         tc
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)    cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == last);

endmodule

// File: rtl/filter_line_ctrl_5x5.sv
// Column/line sequencer for the 5x5 window-align stage: read enable, memory rotation,
// addresses, vertical pad flags and the two synthesised flush lines at frame end.
module filter_line_ctrl_5x5
  import filter_ctrl_pkg::*;
#(
  parameter int unsigned MEM_ADDR_WIDTH = 11,
  parameter int unsigned H_ACT          = 1920,
  parameter int unsigned V_ACT          = 1080,
  parameter int unsigned FLUSH_GAP      = 280
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      i_vsync,
  input  logic                      i_de,
  output logic                      o_mem_ren,
  output logic [1:0]                o_mem_sel,
  output logic [MEM_ADDR_WIDTH-1:0] o_mem_waddr,
  output logic [MEM_ADDR_WIDTH-1:0] o_mem_raddr,
  output logic [3:0]                o_pad_y,
  output logic                      o_busy,
  output logic                      o_frame_done,
  output logic                      o_err
);

  localparam int unsigned TMAX = (FLUSH_GAP > H_ACT) ? FLUSH_GAP : H_ACT;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam int unsigned LW   = $clog2(V_ACT + 3);

  localparam logic [MEM_ADDR_WIDTH-1:0] LINE_LEN   = MEM_ADDR_WIDTH'(H_ACT);
  localparam logic [TW-1:0]             GAP_LAST   = TW'(FLUSH_GAP - 2);
  localparam logic [TW-1:0]             FLUSH_LAST = TW'(H_ACT - 1);

  state_t                    state;
  logic [LW-1:0]             line;
  logic                      act_d1, act_d2, flush_ren;
  logic [1:0]                sel;
  logic [3:0]                pad;
  logic [MEM_ADDR_WIDTH-1:0] waddr;
  logic                      err, frame_done;

  logic                      de_ok, act, line_end, sel_edge;
  logic [MEM_ADDR_WIDTH-1:0] col;
  logic                      col_tc;
  logic                      tmr_en, tmr_clr, tmr_tc;
  logic [TW-1:0]             tmr_last, tmr_cnt_unused;

  // Line index L maps to centre line c = L-2; input lines 0 and 1 have no centre yet.
  function automatic logic [3:0] pad_of(input logic [LW-1:0] l);
    pad_of = '0;
    if (l == LW'(2))              pad_of = PAD_TOP0;
    else if (l == LW'(3))         pad_of = PAD_TOP1;
    else if (l == LW'(V_ACT + 1)) pad_of = PAD_BOT0;
    else if (l == LW'(V_ACT))     pad_of = PAD_BOT1;
  endfunction

  assign de_ok    = rstn & i_de & ~i_vsync & (state inside {IDLE, FILL, RUN});
  assign act      = de_ok | flush_ren;
  assign line_end = act_d1 & ~act;
  assign sel_edge = act_d2 & ~act_d1;

  filter_col_cnt #(.W(MEM_ADDR_WIDTH)) u_col (
    .clk  (clk),
    .rstn (rstn),
    .clr  (i_vsync | line_end),
    .en   (act),
    .last (LINE_LEN),
    .cnt  (col),
    .tc   (col_tc)
  );

  // The line-end cycle is the first idle cycle, so GAP itself runs FLUSH_GAP-1 cycles.
  assign tmr_en   = (state == GAP) | flush_ren;
  assign tmr_clr  = i_vsync | ~tmr_en | tmr_tc;
  assign tmr_last = flush_ren ? FLUSH_LAST : GAP_LAST;

  filter_col_cnt #(.W(TW)) u_tmr (
    .clk  (clk),
    .rstn (rstn),
    .clr  (tmr_clr),
    .en   (tmr_en),
    .last (tmr_last),
    .cnt  (tmr_cnt_unused),
    .tc   (tmr_tc)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      line       <= '0;
      act_d1     <= 1'b0;
      act_d2     <= 1'b0;
      flush_ren  <= 1'b0;
      sel        <= '0;
      pad        <= '0;
      waddr      <= '0;
      err        <= 1'b0;
      frame_done <= 1'b0;
    end else if (i_vsync) begin
      state      <= IDLE;
      line       <= '0;
      act_d1     <= 1'b0;
      act_d2     <= 1'b0;
      flush_ren  <= 1'b0;
      sel        <= '0;
      pad        <= '0;
      waddr      <= '0;
      err        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      act_d1     <= act;
      act_d2     <= act_d1;
      waddr      <= col;
      frame_done <= 1'b0;
      if (line_end) begin
        line <= line + 1'b1;
        if (!col_tc) err <= 1'b1;
      end
      if (sel_edge) begin
        sel <= sel + 2'd1;
        pad <= pad_of(line);
      end
      if (flush_ren && tmr_tc) flush_ren <= 1'b0;
      case (state)
        IDLE:  if (de_ok) state <= FILL;
        FILL:  if (line_end && line == LW'(1)) state <= RUN;
        RUN:   if (line_end && line == LW'(V_ACT - 1)) state <= GAP;
        GAP:   if (tmr_tc) begin
                 state     <= FLUSH;
                 flush_ren <= 1'b1;
               end
        FLUSH: if (line_end) begin
                 if (line == LW'(V_ACT)) begin
                   state <= GAP;
                 end else begin
                   state      <= DONE;
                   frame_done <= 1'b1;
                 end
               end
        DONE: begin
          state <= IDLE;
          line  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_mem_ren    = ((state == RUN) & de_ok) | flush_ren;
  assign o_mem_sel    = sel;
  assign o_mem_waddr  = waddr;
  assign o_mem_raddr  = col;
  assign o_pad_y      = pad;
  assign o_busy       = (state inside {FILL, RUN, GAP, FLUSH}) | ((state == IDLE) & de_ok);
  assign o_frame_done = frame_done;
  assign o_err        = err;

endmodule
